// File: rtl/snitch_outstanding_limiter_if.sv
// Request/response handshake bundle for snitch_outstanding_limiter.
// One bit per channel on every signal.
//   req_valid_i / req_ready_o : upstream (core side) request handshake
//   req_valid_o / req_ready_i : downstream (interconnect side) request handshake
//   rsp_valid_i / rsp_ready_i : response handshake, observed only
// slave  : the limiter's view of the bundle.
// master : the environment's view (cores plus interconnect).
interface snitch_outstanding_limiter_if #(
  parameter int unsigned NumChannels = 8
);
  logic [NumChannels-1:0] req_valid_i;
  logic [NumChannels-1:0] req_ready_o;
  logic [NumChannels-1:0] req_valid_o;
  logic [NumChannels-1:0] req_ready_i;
  logic [NumChannels-1:0] rsp_valid_i;
  logic [NumChannels-1:0] rsp_ready_i;

  modport slave (
    input  req_valid_i, req_ready_i, rsp_valid_i, rsp_ready_i,
    output req_valid_o, req_ready_o
  );

  modport master (
    output req_valid_i, req_ready_i, rsp_valid_i, rsp_ready_i,
    input  req_valid_o, req_ready_o
  );
endinterface

// File: rtl/snitch_outstanding_limiter.sv
// Per-channel outstanding-transaction limiter.
// Each channel counts accepted requests minus observed responses and closes
// its request gate when the count reaches a runtime-programmable limit, or
// while the channel is draining or halted. Gating is purely combinational on
// registered state; nothing is buffered.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   bus            snitch_outstanding_limiter_if.slave handshake bundle
//   cfg_we_i       limit write strobe; cfg_ch_i selects channel,
//                  cfg_limit_i gives the value (clamped to MaxOutstanding)
//   drain_i        per-channel drain request (RUN -> DRAIN -> HALT)
//   resume_i       per-channel resume (HALT -> RUN)
//   halted_o       channel is halted
//   count_o        per-channel outstanding count
//   err_o          sticky: response seen while count was 0
//   stall_cnt_o    per-channel stall-cycle counter, present only when the
//                  SNITCH_OSL_STATS_EN macro is defined

module snitch_osl_lane #(
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned DefaultLimit   = 4,
  parameter int unsigned CntW           = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  input  logic            req_ready_i,
  input  logic            rsp_valid_i,
  input  logic            rsp_ready_i,
  input  logic            limit_we_i,
  input  logic [CntW-1:0] limit_i,
  input  logic            drain_i,
  input  logic            resume_i,
  output logic            gate_o,
  output logic [CntW-1:0] count_o,
  output logic            halted_o,
  output logic            err_o
`ifdef SNITCH_OSL_STATS_EN
  ,
  output logic [31:0]     stall_cnt_o
`endif
);
  typedef enum logic [1:0] {Run, Drain, Halt} state_e;

  localparam logic [CntW-1:0] MaxLim = CntW'(MaxOutstanding);
  localparam logic [CntW-1:0] DefLim = CntW'(DefaultLimit);

  state_e          state_q;
  logic [CntW-1:0] cnt_q, lim_q;
  logic            err_q;
  logic            req_hs, rsp_hs;

  // Gate only looks at registered state, so a same-cycle drain or limit
  // write is judged against the old values.
  assign gate_o   = (state_q == Run) && (cnt_q < lim_q);
  assign req_hs   = req_valid_i & req_ready_i & gate_o;
  assign rsp_hs   = rsp_valid_i & rsp_ready_i;
  assign count_o  = cnt_q;
  assign halted_o = (state_q == Halt);
  assign err_o    = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Run;
      cnt_q   <= '0;
      lim_q   <= DefLim;
      err_q   <= 1'b0;
    end else begin
      if (req_hs && !rsp_hs)
        cnt_q <= cnt_q + CntW'(1);
      else if (rsp_hs && !req_hs && cnt_q != '0)
        cnt_q <= cnt_q - CntW'(1);
      // A response with nothing outstanding cannot be matched to anything.
      if (rsp_hs && cnt_q == '0)
        err_q <= 1'b1;
      if (limit_we_i)
        lim_q <= (limit_i > MaxLim) ? MaxLim : limit_i;
      unique case (state_q)
        Run:     if (drain_i)        state_q <= Drain;
        Drain:   if (cnt_q == '0)    state_q <= Halt;
        Halt:    if (resume_i)       state_q <= Run;
        default:                     state_q <= Run;
      endcase
    end
  end

`ifdef SNITCH_OSL_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      stall_cnt_o <= '0;
    else if (limit_we_i)
      stall_cnt_o <= '0;
    else if (req_valid_i && !gate_o && stall_cnt_o != 32'hFFFF_FFFF)
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif
endmodule

module snitch_outstanding_limiter #(
  parameter int unsigned NumChannels    = 8,
  parameter int unsigned MaxOutstanding = 16,
  parameter int unsigned DefaultLimit   = 4,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1),
  localparam int unsigned ChW  = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  snitch_outstanding_limiter_if.slave       bus,
  input  logic                              cfg_we_i,
  input  logic [ChW-1:0]                    cfg_ch_i,
  input  logic [CntW-1:0]                   cfg_limit_i,
  input  logic [NumChannels-1:0]            drain_i,
  input  logic [NumChannels-1:0]            resume_i,
  output logic [NumChannels-1:0]            halted_o,
  output logic [NumChannels-1:0][CntW-1:0]  count_o,
  output logic [NumChannels-1:0]            err_o
`ifdef SNITCH_OSL_STATS_EN
  ,
  output logic [NumChannels-1:0][31:0]      stall_cnt_o
`endif
);
  logic [NumChannels-1:0] gate;

  for (genvar g = 0; g < NumChannels; g++) begin : g_lane
    logic we;
    // Out-of-range channel indices match no lane and are dropped here.
    assign we = cfg_we_i && (int'(cfg_ch_i) == g);

    assign bus.req_valid_o[g] = bus.req_valid_i[g] & gate[g];
    assign bus.req_ready_o[g] = bus.req_ready_i[g] & gate[g];

    snitch_osl_lane #(
      .MaxOutstanding (MaxOutstanding),
      .DefaultLimit   (DefaultLimit),
      .CntW           (CntW)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_valid_i (bus.req_valid_i[g]),
      .req_ready_i (bus.req_ready_i[g]),
      .rsp_valid_i (bus.rsp_valid_i[g]),
      .rsp_ready_i (bus.rsp_ready_i[g]),
      .limit_we_i  (we),
      .limit_i     (cfg_limit_i),
      .drain_i     (drain_i[g]),
      .resume_i    (resume_i[g]),
      .gate_o      (gate[g]),
      .count_o     (count_o[g]),
      .halted_o    (halted_o[g]),
      .err_o       (err_o[g])
`ifdef SNITCH_OSL_STATS_EN
      ,
      .stall_cnt_o (stall_cnt_o[g])
`endif
    );
  end
endmodule

// File: tb/tb_snitch_outstanding_limiter.sv
// Randomized scoreboard bench for snitch_outstanding_limiter.
module tb_snitch_outstanding_limiter;
  localparam int N    = 6;   // non power of two: channel indices 6,7 are out of range
  localparam int MAX  = 16;
  localparam int DEF  = 4;
  localparam int CW   = $clog2(MAX + 1);
  localparam int CHW  = $clog2(N);
  localparam int NCYC = 3600;

  logic clk = 1'b0;
  logic rst_i;
  logic cfg_we;
  logic [CHW-1:0] cfg_ch;
  logic [CW-1:0]  cfg_limit;
  logic [N-1:0]   drain, resume, halted, err;
  logic [N-1:0][CW-1:0] count;
`ifdef SNITCH_OSL_STATS_EN
  logic [N-1:0][31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  snitch_outstanding_limiter_if #(.NumChannels(N)) bus ();

  snitch_outstanding_limiter #(
    .NumChannels(N), .MaxOutstanding(MAX), .DefaultLimit(DEF)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .bus(bus),
    .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch), .cfg_limit_i(cfg_limit),
    .drain_i(drain), .resume_i(resume),
    .halted_o(halted), .count_o(count), .err_o(err)
`ifdef SNITCH_OSL_STATS_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  typedef struct {
    int cyc;
    logic [N-1:0] rdy, vld, hlt, er;
    logic [N-1:0][CW-1:0] cnt;
    logic [N-1:0][31:0] st;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: outstanding totals and channel mode per channel.
  // mode: 0 = running, 1 = draining, 2 = halted
  int          m_out[N], m_lim[N], m_mode[N];
  bit          m_err[N];
  int unsigned m_st[N];

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      m_out[c] = 0; m_lim[c] = DEF; m_mode[c] = 0; m_err[c] = 0; m_st[c] = 0;
    end
  endfunction

  task automatic chk(input string nm, input int cyc, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic driver();
    exp_t e;
    bit open, acc, ret;
    int rsp_pct;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      rsp_pct = (cyc / 400) % 4 == 0 ? 5 : (cyc / 400) % 4 == 1 ? 40 : (cyc / 400) % 4 == 2 ? 70 : 20;
      rst_i = (cyc == 1300 || cyc == 2600);
      cfg_we    = ($urandom_range(0, 19) == 0);
      cfg_ch    = CHW'($urandom_range(0, (1 << CHW) - 1));
      cfg_limit = CW'($urandom_range(0, MAX + 7));
      for (int c = 0; c < N; c++) begin
        bus.req_valid_i[c] = ($urandom_range(0, 3) != 0);
        bus.req_ready_i[c] = ($urandom_range(0, 3) != 0);
        bus.rsp_ready_i[c] = ($urandom_range(0, 3) != 0);
        bus.rsp_valid_i[c] = (m_out[c] > 0) && ($urandom_range(0, 99) < rsp_pct);
        // occasional stray response with nothing outstanding
        if (m_out[c] == 0 && $urandom_range(0, 149) == 0) begin
          bus.rsp_valid_i[c] = 1'b1; bus.rsp_ready_i[c] = 1'b1; bus.req_valid_i[c] = 1'b0;
        end
        drain[c]  = ($urandom_range(0, 59) == 0);
        resume[c] = ($urandom_range(0, 14) == 0);
      end
      if (rst_i) model_reset();
      e.cyc = cyc;
      for (int c = 0; c < N; c++) begin
        open = (m_mode[c] == 0) && (m_out[c] < m_lim[c]);
        e.rdy[c] = bus.req_ready_i[c] & open;
        e.vld[c] = bus.req_valid_i[c] & open;
        e.cnt[c] = CW'(m_out[c]);
        e.hlt[c] = (m_mode[c] == 2);
        e.er[c]  = m_err[c];
        e.st[c]  = m_st[c];
      end
      q.push_back(e);
      if (!rst_i) begin
        for (int c = 0; c < N; c++) begin
          open = (m_mode[c] == 0) && (m_out[c] < m_lim[c]);
          acc  = bus.req_valid_i[c] && bus.req_ready_i[c] && open;
          ret  = bus.rsp_valid_i[c] && bus.rsp_ready_i[c];
          if (ret && m_out[c] == 0) m_err[c] = 1;
          if (acc && !ret) m_out[c]++;
          else if (ret && !acc && m_out[c] > 0) m_out[c]--;
          if (cfg_we && int'(cfg_ch) == c) m_st[c] = 0;
          else if (bus.req_valid_i[c] && !open && m_st[c] != 32'hFFFF_FFFF) m_st[c]++;
          case (m_mode[c])
            0: if (drain[c]) m_mode[c] = 1;
            1: if (e.cnt[c] == 0) m_mode[c] = 2;
            default: if (resume[c]) m_mode[c] = 0;
          endcase
        end
        if (cfg_we && int'(cfg_ch) < N)
          m_lim[cfg_ch] = (int'(cfg_limit) > MAX) ? MAX : int'(cfg_limit);
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      #2;
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL queue_empty cyc=%0d got=0 exp=1", i);
      end else begin
        e = q.pop_front();
        chk("req_ready_o", e.cyc, 256'(bus.req_ready_o), 256'(e.rdy));
        chk("req_valid_o", e.cyc, 256'(bus.req_valid_o), 256'(e.vld));
        chk("count_o",     e.cyc, 256'(count),           256'(e.cnt));
        chk("halted_o",    e.cyc, 256'(halted),          256'(e.hlt));
        chk("err_o",       e.cyc, 256'(err),             256'(e.er));
`ifdef SNITCH_OSL_STATS_EN
        chk("stall_cnt_o", e.cyc, 256'(stall_cnt),       256'(e.st));
`endif
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_limit = '0;
    drain = '0; resume = '0;
    bus.req_valid_i = '0; bus.req_ready_i = '0;
    bus.rsp_valid_i = '0; bus.rsp_ready_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    fork
      driver();
      monitor();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
